dp_ecc_ram_ctrl: RTL and testbench

- Dual-port (A/B) single-clock RAM controller with SECDED Hamming protection.
- Each port independently reads or writes a shared array of 2^ADDR_A words. Write and read latency are configurable per port.
- Writes are encoded, optionally corrupted by an XOR inject mask, then stored. Reads are decoded: single-bit errors are corrected silently and double-bit errors are flagged.

---
 rtl/dp_ecc_ram_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dp_ecc_ram_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ecc_ram_ctrl.sv
// Dual-port, single-clock RAM controller with SECDED Hamming protection.
// Each port has its own write/read latency; port A wins same-address write collisions.
module dp_ecc_ram_ctrl #(
  parameter  int unsigned DATA_A      = 32,
  parameter  int unsigned ADDR_A      = 6,
  parameter  int unsigned WR_LATENCYA = 2,
  parameter  int unsigned WR_LATENCYB = 2,
  parameter  int unsigned RD_LATENCYA = 3,
  parameter  int unsigned RD_LATENCYB = 3,
  // Fixed-point iteration of P = clog2(D+P+1); converges to the smallest valid P.
  localparam int unsigned P  = $clog2(DATA_A + $clog2(DATA_A + $clog2(DATA_A +
                                      $clog2(DATA_A + 1) + 1) + 1) + 1),
  localparam int unsigned CW = DATA_A + P + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ena,
  input  logic              i_wea,
  input  logic [ADDR_A-1:0] i_addra,
  input  logic [DATA_A-1:0] i_data_in_a,
  input  logic [CW-1:0]     i_inj_a,
  output logic [DATA_A-1:0] o_dout_a,
  output logic              o_dbit_err_a,
  input  logic              i_enb,
  input  logic              i_web,
  input  logic [ADDR_A-1:0] i_addrb,
  input  logic [DATA_A-1:0] i_data_in_b,
  input  logic [CW-1:0]     i_inj_b,
  output logic [DATA_A-1:0] o_dout_b,
  output logic              o_dbit_err_b
);

  localparam int unsigned D     = DATA_A;
  localparam int unsigned Depth = 2 ** ADDR_A;

  // Codeword bit i is Hamming position i; bit 0 is overall even parity.
  function automatic logic [CW-1:0] encode(input logic [D-1:0] d);
    logic [CW-1:0] c;
    int unsigned   k;
    c = '0;
    k = 0;
    for (int unsigned i = 1; i < CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[k];
        k++;
      end
    end
    for (int unsigned j = 0; j < P; j++) begin
      for (int unsigned i = 1; i < CW; i++) begin
        if (i[j] && (i != (32'd1 << j))) c[32'd1 << j] = c[32'd1 << j] ^ c[i];
      end
    end
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  // Returns {double_err, data}.
  function automatic logic [D:0] decode(input logic [CW-1:0] c);
    logic [P-1:0]  s;
    logic          g;
    logic [CW-1:0] f;
    logic [D-1:0]  d;
    int unsigned   k;
    s = '0;
    for (int unsigned i = 1; i < CW; i++) begin
      if (c[i]) s = s ^ i[P-1:0];
    end
    g = ^c;
    f = c;
    if (g && (s != '0) && (32'(s) < CW)) f[s] = ~f[s];
    d = '0;
    k = 0;
    for (int unsigned i = 1; i < CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = f[i];
        k++;
      end
    end
    return {(s != '0) && !g, d};
  endfunction

  logic              en      [2];
  logic              we      [2];
  logic [ADDR_A-1:0] addr    [2];
  logic [D-1:0]      wdata   [2];
  logic [CW-1:0]     inj     [2];
  logic              wr_v    [2];
  logic [ADDR_A-1:0] wr_addr [2];
  logic [CW-1:0]     wr_cw   [2];
  logic [D:0]        rd_res  [2];
  logic [CW-1:0]     mem_q   [Depth];

  assign en[0]    = i_ena;
  assign en[1]    = i_enb;
  assign we[0]    = i_wea;
  assign we[1]    = i_web;
  assign addr[0]  = i_addra;
  assign addr[1]  = i_addrb;
  assign wdata[0] = i_data_in_a;
  assign wdata[1] = i_data_in_b;
  assign inj[0]   = i_inj_a;
  assign inj[1]   = i_inj_b;

  // Port A is applied last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_v[1]) mem_q[wr_addr[1]] <= wr_cw[1];
    if (wr_v[0]) mem_q[wr_addr[0]] <= wr_cw[0];
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int unsigned Wl = (p == 0) ? WR_LATENCYA : WR_LATENCYB;
    localparam int unsigned Rl = (p == 0) ? RD_LATENCYA : RD_LATENCYB;

    logic          req_wr;
    logic          req_rd;
    logic [CW-1:0] cw_in;
    logic [D:0]    rd_dec;
    logic          fin_v;
    logic [D:0]    fin_d;
    logic [D:0]    out_q;

    assign req_wr = en[p] & we[p] & ~rst;
    assign req_rd = en[p] & ~we[p] & ~rst;
    assign cw_in  = encode(wdata[p]) ^ inj[p];
    assign rd_dec = decode(mem_q[addr[p]]);

    if (Wl == 1) begin : g_wr_direct
      assign wr_v[p]    = req_wr;
      assign wr_addr[p] = addr[p];
      assign wr_cw[p]   = cw_in;
    end else begin : g_wr_pipe
      logic [Wl-2:0]     v_q;
      logic [ADDR_A-1:0] a_q [Wl-1];
      logic [CW-1:0]     c_q [Wl-1];
      always_ff @(posedge clk) begin
        v_q[0] <= req_wr;
        a_q[0] <= addr[p];
        c_q[0] <= cw_in;
        for (int unsigned i = 1; i < Wl - 1; i++) begin
          v_q[i] <= v_q[i-1] & ~rst;
          a_q[i] <= a_q[i-1];
          c_q[i] <= c_q[i-1];
        end
      end
      assign wr_v[p]    = v_q[Wl-2] & ~rst;
      assign wr_addr[p] = a_q[Wl-2];
      assign wr_cw[p]   = c_q[Wl-2];
    end

    if (Rl == 1) begin : g_rd_direct
      assign fin_v = req_rd;
      assign fin_d = rd_dec;
    end else begin : g_rd_pipe
      logic [Rl-2:0] v_q;
      logic [D:0]    d_q [Rl-1];
      always_ff @(posedge clk) begin
        v_q[0] <= req_rd;
        d_q[0] <= rd_dec;
        for (int unsigned i = 1; i < Rl - 1; i++) begin
          v_q[i] <= v_q[i-1] & ~rst;
          d_q[i] <= d_q[i-1];
        end
      end
      assign fin_v = v_q[Rl-2];
      assign fin_d = d_q[Rl-2];
    end

    // Holds the last read result; writes never disturb it.
    always_ff @(posedge clk) begin
      if (rst)        out_q <= '0;
      else if (fin_v) out_q <= fin_d;
    end

    assign rd_res[p] = out_q;
  end

  assign o_dout_a     = rd_res[0][D-1:0];
  assign o_dbit_err_a = rd_res[0][D];
  assign o_dout_b     = rd_res[1][D-1:0];
  assign o_dbit_err_b = rd_res[1][D];

endmodule

// File: tb/tb_dp_ecc_ram_ctrl.sv
// Directed bench for dp_ecc_ram_ctrl with asymmetric latencies (A: WR1/RD4, B: WR3/RD1).
module tb_dp_ecc_ram_ctrl;
  localparam int unsigned WLA = 1;
  localparam int unsigned RLA = 4;
  localparam int unsigned WLB = 3;
  localparam int unsigned RLB = 1;
  localparam int NV = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena, wea, enb, web;
  logic [5:0]  addra, addrb;
  logic [31:0] dina, dinb, douta, doutb;
  logic [38:0] inja, injb;
  logic        erra, errb;

  dp_ecc_ram_ctrl #(
    .DATA_A     (32),
    .ADDR_A     (6),
    .WR_LATENCYA(WLA),
    .WR_LATENCYB(WLB),
    .RD_LATENCYA(RLA),
    .RD_LATENCYB(RLB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ena       (ena),
    .i_wea       (wea),
    .i_addra     (addra),
    .i_data_in_a (dina),
    .i_inj_a     (inja),
    .o_dout_a    (douta),
    .o_dbit_err_a(erra),
    .i_enb       (enb),
    .i_web       (web),
    .i_addrb     (addrb),
    .i_data_in_b (dinb),
    .i_inj_b     (injb),
    .o_dout_b    (doutb),
    .o_dbit_err_b(errb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [38:0] inj;
    logic        exp_e;
    logic [31:0] exp_d;
  } vec_t;

  vec_t        vecs [NV];
  vec_t        v;
  logic [32:0] last [2];
  int          checks = 0;
  int          failures = 0;

  function automatic vec_t mk(input logic port, input logic we, input logic [5:0] a,
                              input logic [31:0] d, input logic [38:0] m,
                              input logic e, input logic [31:0] xd);
    return '{port, we, a, d, m, e, xd};
  endfunction

  function automatic logic [31:0] da(input int i);
    return 32'hC3000000 ^ (32'(i) * 32'h01010101);
  endfunction

  function automatic logic [31:0] db(input int i);
    return 32'h5A5A0000 + (32'(i) * 32'h00001111);
  endfunction

  function automatic logic [32:0] out_of(input logic port);
    return port ? {errb, doutb} : {erra, douta};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0;
  endtask

  task automatic drive(input logic port, input logic we, input logic [5:0] a,
                       input logic [31:0] d, input logic [38:0] m);
    if (!port) begin
      ena = 1'b1; wea = we; addra = a; dina = d; inja = m;
    end else begin
      enb = 1'b1; web = we; addrb = a; dinb = d; injb = m;
    end
  endtask

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got err=%0b data=%08h, want err=%0b data=%08h",
               nm, act[32], act[31:0], exp[32], exp[31:0]);
    end
  endtask

  initial begin
    vecs[0]  = mk(0, 1, 6'd5,  32'hDEADBEEF, 39'd0,                      0, 32'h0);
    vecs[1]  = mk(0, 0, 6'd5,  32'h0,        39'd0,                      0, 32'hDEADBEEF);
    vecs[2]  = mk(1, 1, 6'd9,  32'h12345678, 39'd1 << 7,                 0, 32'h0);
    vecs[3]  = mk(0, 0, 6'd9,  32'h0,        39'd0,                      0, 32'h12345678);
    vecs[4]  = mk(1, 1, 6'd9,  32'h12345678, 39'd1,                      0, 32'h0);
    vecs[5]  = mk(0, 0, 6'd9,  32'h0,        39'd0,                      0, 32'h12345678);
    vecs[6]  = mk(0, 1, 6'd3,  32'hA5A5A5A5, (39'd1 << 3) | (39'd1 << 10), 0, 32'h0);
    // Double error: positions 3 and 10 are data bits 0 and 5, left uncorrected.
    vecs[7]  = mk(0, 0, 6'd3,  32'h0,        39'd0,                      1, 32'hA5A5A584);
    vecs[8]  = mk(0, 0, 6'd5,  32'h0,        39'd0,                      0, 32'hDEADBEEF);
    vecs[9]  = mk(1, 1, 6'd20, 32'h0F0F0F0F, 39'd1 << 38,                0, 32'h0);
    vecs[10] = mk(1, 0, 6'd20, 32'h0,        39'd0,                      0, 32'h0F0F0F0F);
    vecs[11] = mk(1, 0, 6'd3,  32'h0,        39'd0,                      1, 32'hA5A5A584);
    vecs[12] = mk(0, 1, 6'd63, 32'h0,        39'd1 << 2,                 0, 32'h0);
    vecs[13] = mk(1, 0, 6'd63, 32'h0,        39'd0,                      0, 32'h0);
    vecs[14] = mk(1, 0, 6'd9,  32'h0,        39'd0,                      0, 32'h12345678);
    vecs[15] = mk(0, 1, 6'd0,  32'hFFFFFFFF, 39'd0,                      0, 32'h0);
    vecs[16] = mk(0, 0, 6'd0,  32'h0,        39'd0,                      0, 32'hFFFFFFFF);

    rst = 1'b1; idle();
    addra = '0; addrb = '0; dina = '0; dinb = '0; inja = '0; injb = '0;
    tick();
    tick();
    chk("reset_a", out_of(1'b0), 33'd0);
    chk("reset_b", out_of(1'b1), 33'd0);
    rst = 1'b0;
    last[0] = '0;
    last[1] = '0;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive(v.port, v.we, v.addr, v.data, v.inj);
      tick();
      idle();
      if (v.we) begin
        repeat (v.port ? WLB : WLA) tick();
        chk($sformatf("vec%0d_wr_hold", i), out_of(v.port), last[v.port]);
      end else begin
        if ((v.port ? RLB : RLA) > 1) begin
          repeat ((v.port ? RLB : RLA) - 2) tick();
          chk($sformatf("vec%0d_early", i), out_of(v.port), last[v.port]);
          tick();
        end
        chk($sformatf("vec%0d_rd", i), out_of(v.port), {v.exp_e, v.exp_d});
        last[v.port] = {v.exp_e, v.exp_d};
      end
    end

    // Both writes to addr 7 commit on the same edge.
    drive(1, 1, 6'd7, 32'h2, 39'd0); tick(); idle();
    tick();
    drive(0, 1, 6'd7, 32'h1, 39'd0); tick(); idle();
    drive(0, 0, 6'd7, 32'h0, 39'd0); tick(); idle();
    repeat (RLA - 1) tick();
    chk("ww_collide_a", out_of(1'b0), {1'b0, 32'h1});
    drive(1, 0, 6'd7, 32'h0, 39'd0); tick(); idle();
    chk("ww_collide_b", out_of(1'b1), {1'b0, 32'h1});

    // Port A reads on the edge port B's write commits, then one cycle later.
    drive(0, 1, 6'd2, 32'h13572468, 39'd0); tick(); idle();
    drive(1, 1, 6'd2, 32'hFFFF0000, 39'd0); tick(); idle();
    tick();
    drive(0, 0, 6'd2, 32'h0, 39'd0); tick();
    tick();
    idle(); tick();
    tick();
    chk("rw_collide_old", out_of(1'b0), {1'b0, 32'h13572468});
    tick();
    chk("rw_collide_new", out_of(1'b0), {1'b0, 32'hFFFF0000});
    last[0] = {1'b0, 32'hFFFF0000};

    // Port B reads on the edge port A's write commits.
    drive(0, 1, 6'd11, 32'h0BADF00D, 39'd0); tick(); idle();
    drive(0, 1, 6'd11, 32'hC0FFEE00, 39'd0);
    drive(1, 0, 6'd11, 32'h0, 39'd0); tick(); idle();
    chk("wr_collide_old_b", out_of(1'b1), {1'b0, 32'h0BADF00D});
    drive(1, 0, 6'd11, 32'h0, 39'd0); tick(); idle();
    chk("wr_collide_new_b", out_of(1'b1), {1'b0, 32'hC0FFEE00});
    last[1] = {1'b0, 32'hC0FFEE00};

    // Streaming: 16 writes per port, B's with a walking single-bit flip.
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 6'(32 + i), da(i), 39'd0);
      drive(1, 1, 6'(48 + i), db(i), 39'd1 << (i + 1));
      tick();
    end
    idle();
    repeat (4) tick();
    for (int t = 0; t < 19; t++) begin
      if (t < 16) begin
        drive(0, 0, 6'(48 + t), 32'h0, 39'd0);
        drive(1, 0, 6'(32 + t), 32'h0, 39'd0);
      end else begin
        idle();
      end
      tick();
      if (t < 16) chk($sformatf("stream_b%0d", t), out_of(1'b1), {1'b0, da(t)});
      else        chk($sformatf("stream_b_hold%0d", t), out_of(1'b1), {1'b0, da(15)});
      if (t >= 3) chk($sformatf("stream_a%0d", t - 3), out_of(1'b0), {1'b0, db(t - 3)});
      else        chk($sformatf("stream_a_hold%0d", t), out_of(1'b0), last[0]);
    end
    idle();

    // Reset while port A reads are still in flight.
    for (int t = 0; t < 3; t++) begin
      drive(0, 0, 6'(48 + t), 32'h0, 39'd0);
      drive(1, 0, 6'(32 + t), 32'h0, 39'd0);
      tick();
      chk($sformatf("pre_rst_b%0d", t), out_of(1'b1), {1'b0, da(t)});
    end
    drive(0, 0, 6'd51, 32'h0, 39'd0);
    drive(1, 0, 6'd35, 32'h0, 39'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("rst_a", out_of(1'b0), 33'd0);
    chk("rst_b", out_of(1'b1), 33'd0);
    for (int t = 0; t < 6; t++) begin
      tick();
      chk($sformatf("post_rst_a%0d", t), out_of(1'b0), 33'd0);
      chk($sformatf("post_rst_b%0d", t), out_of(1'b1), 33'd0);
    end

    drive(0, 0, 6'd32, 32'h0, 39'd0); tick(); idle();
    repeat (RLA - 1) tick();
    chk("recover_a", out_of(1'b0), {1'b0, da(0)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
